reset_seq: RTL and testbench

Parametrised board reset controller; successor to the single-channel debounce reset used in the top level.
- Combines SRC asynchronous "ok" sources (button, PLL lock, etc.) and a software reset request.
- Debounces the combined condition.
- Releases CH active-low domain resets in fixed order 0..CH-1, with a programmable stagger between domains.
- Latches the cause of the last reset for software.

---
 rtl/reset_seq.sv | 157 +++++++++++++++
 tb/tb_reset_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Board reset controller: synchronises and debounces the reset-condition sources,
// then releases the active-low domain resets in index order and records the fault cause.
module reset_seq #(
  parameter int SRC      = 2,
  parameter int CH       = 3,
  parameter int DEBOUNCE = 500,
  parameter int STAGGER  = 16,
  parameter int SYNC     = 2,
  parameter int CW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SRC-1:0] src_ok,
  input  logic           sw_req,
  input  logic           cause_clr,
  output logic [CH-1:0]  rst_n_o,
  output logic           ready,
  output logic [SRC:0]   cause
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [1:0] S_HOLD     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_RELEASE  = 2'd2;
  localparam logic [1:0] S_RUN      = 2'd3;

  logic [SYNC-1:0][SRC-1:0] sync_q;
  logic [SRC-1:0]           ok_s;
  logic                     all_ok_s;
  logic                     fault_s;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CH-1:0] rst_n_q, rst_n_d;
  logic          ready_q, ready_d;
  logic [SRC:0]  cause_q, cause_d;
  logic [SRC:0]  set_s;

  assign ok_s     = sync_q[SYNC-1];
  assign all_ok_s = &ok_s;
  assign fault_s  = !all_ok_s || sw_req;

  // Synchroniser chain for the asynchronous source levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= src_ok;
      for (int i = 1; i < SYNC; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Sequencer next-state: debounce, staggered release, collective re-assert on fault.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    set_s   = '0;
    case (state_q)
      S_HOLD: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        if (all_ok_s) begin
          state_d = S_DEBOUNCE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DEBOUNCE: begin
        if (fault_s) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE)) begin
          // Domain 0 leaves reset on the same edge the debounce completes.
          rst_n_d = CH'(1);
          cnt_d   = '0;
          idx_d   = IW'(1);
          if (CH == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (fault_s) begin
          state_d = S_HOLD;
          rst_n_d = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          set_s   = {sw_req, ~ok_s};
        end else if (state_q == S_RELEASE) begin
          if (cnt_q == CW'(STAGGER - 1)) begin
            // Shifting in a one keeps the released set contiguous from domain 0.
            rst_n_d = (rst_n_q << 1) | CH'(1);
            cnt_d   = '0;
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(CH - 1)) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase
    cause_d = (cause_q & ~{(SRC+1){cause_clr}}) | set_s;
  end

  // Sequencer and cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign ready   = ready_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed table-driven bench for reset_seq (SRC=2, CH=3, DEBOUNCE=8, STAGGER=4)
// with a second CH=1, STAGGER=1 instance sharing the same stimulus.
module tb_reset_seq;

  logic       clk;
  logic       rst;
  logic [1:0] src_ok;
  logic       sw_req;
  logic       cause_clr;
  logic [2:0] rst_n_o;
  logic       ready;
  logic [2:0] cause;
  logic [0:0] rst_n1;
  logic       ready1;
  logic [2:0] cause1;

  int vec_cnt;
  int err_cnt;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] src;
    logic       sw;
    logic       clr;
    int         ncyc;
    logic [2:0] rn;
    logic       rdy;
    logic [2:0] cause;
  } vec_t;

  vec_t vecs[$];

  reset_seq #(.SRC(2), .CH(3), .DEBOUNCE(8), .STAGGER(4), .SYNC(2), .CW(16)) dut (
    .clk(clk), .rst(rst), .src_ok(src_ok), .sw_req(sw_req), .cause_clr(cause_clr),
    .rst_n_o(rst_n_o), .ready(ready), .cause(cause)
  );

  reset_seq #(.SRC(2), .CH(1), .DEBOUNCE(8), .STAGGER(1), .SYNC(2), .CW(16)) dut1 (
    .clk(clk), .rst(rst), .src_ok(src_ok), .sw_req(sw_req), .cause_clr(cause_clr),
    .rst_n_o(rst_n1), .ready(ready1), .cause(cause1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input logic r, input logic [1:0] s, input logic w,
                     input logic c, input int k, input logic [2:0] rn, input logic rdy,
                     input logic [2:0] ca);
    vec_t v;
    v.name = n; v.rst = r; v.src = s; v.sw = w; v.clr = c; v.ncyc = k;
    v.rn = rn; v.rdy = rdy; v.cause = ca;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [8:0] exp);
    logic [8:0] got;
    got = {rst_n_o, ready, cause, rst_n1[0], ready1};
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got rst_n/ready/cause/rst_n1/ready1=%b required %b", n, got, exp);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1; src_ok = 2'b00; sw_req = 1'b0; cause_clr = 1'b0;

    // name rst src sw clr ncyc rst_n ready cause (edges counted from the row's first edge)
    add("reset",         1'b1, 2'b00, 1'b0, 1'b0, 3,  3'b000, 1'b0, 3'b000);
    add("s1_edge10",     1'b0, 2'b11, 1'b0, 1'b0, 11, 3'b000, 1'b0, 3'b000);
    add("s1_edge11",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b001, 1'b0, 3'b000);
    add("s1_edge14",     1'b0, 2'b11, 1'b0, 1'b0, 3,  3'b001, 1'b0, 3'b000);
    add("s1_edge15",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b011, 1'b0, 3'b000);
    add("s1_edge18",     1'b0, 2'b11, 1'b0, 1'b0, 3,  3'b011, 1'b0, 3'b000);
    add("s1_edge19",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b111, 1'b1, 3'b000);
    add("s2_rst",        1'b1, 2'b11, 1'b0, 1'b0, 1,  3'b000, 1'b0, 3'b000);
    add("s2_deb",        1'b0, 2'b11, 1'b0, 1'b0, 8,  3'b000, 1'b0, 3'b000);
    add("s2_glitch",     1'b0, 2'b10, 1'b0, 1'b0, 1,  3'b000, 1'b0, 3'b000);
    add("s2_edge19",     1'b0, 2'b11, 1'b0, 1'b0, 11, 3'b000, 1'b0, 3'b000);
    add("s2_edge20",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b001, 1'b0, 3'b000);
    add("s2_edge28",     1'b0, 2'b11, 1'b0, 1'b0, 8,  3'b111, 1'b1, 3'b000);
    add("s3_drop",       1'b0, 2'b01, 1'b0, 1'b0, 1,  3'b111, 1'b1, 3'b000);
    add("s3_sync",       1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b111, 1'b1, 3'b000);
    add("s3_fault",      1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b000, 1'b0, 3'b010);
    add("s3_edge11",     1'b0, 2'b11, 1'b0, 1'b0, 9,  3'b000, 1'b0, 3'b010);
    add("s3_edge12",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b001, 1'b0, 3'b010);
    add("s3_edge20",     1'b0, 2'b11, 1'b0, 1'b0, 8,  3'b111, 1'b1, 3'b010);
    add("s6_clr_race",   1'b0, 2'b11, 1'b1, 1'b1, 1,  3'b000, 1'b0, 3'b100);
    add("s6_edge9",      1'b0, 2'b11, 1'b0, 1'b0, 9,  3'b000, 1'b0, 3'b100);
    add("s6_edge10",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b001, 1'b0, 3'b100);
    add("s6_edge18",     1'b0, 2'b11, 1'b0, 1'b0, 8,  3'b111, 1'b1, 3'b100);
    add("clr_only",      1'b0, 2'b11, 1'b0, 1'b1, 1,  3'b111, 1'b1, 3'b000);
    add("s4_sw",         1'b0, 2'b11, 1'b1, 1'b0, 1,  3'b000, 1'b0, 3'b100);
    add("s4_edge9",      1'b0, 2'b11, 1'b0, 1'b0, 9,  3'b000, 1'b0, 3'b100);
    add("s4_edge10",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b001, 1'b0, 3'b100);
    add("s4_edge14",     1'b0, 2'b11, 1'b0, 1'b0, 4,  3'b011, 1'b0, 3'b100);
    add("s4_edge18",     1'b0, 2'b11, 1'b0, 1'b0, 4,  3'b111, 1'b1, 3'b100);
    add("s5_sw",         1'b0, 2'b11, 1'b1, 1'b0, 1,  3'b000, 1'b0, 3'b100);
    add("s5_rel0",       1'b0, 2'b11, 1'b0, 1'b0, 10, 3'b001, 1'b0, 3'b100);
    add("s5_rst",        1'b1, 2'b11, 1'b0, 1'b0, 1,  3'b000, 1'b0, 3'b000);
    add("s5_edge10",     1'b0, 2'b11, 1'b0, 1'b0, 11, 3'b000, 1'b0, 3'b000);
    add("s5_edge11",     1'b0, 2'b11, 1'b0, 1'b0, 1,  3'b001, 1'b0, 3'b000);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; src_ok = vecs[k].src; sw_req = vecs[k].sw; cause_clr = vecs[k].clr;
      @(posedge clk);
      #1 sw_req = 1'b0; cause_clr = 1'b0;
      repeat (vecs[k].ncyc - 1) @(posedge clk);
      @(negedge clk);
      check(vecs[k].name, {vecs[k].rn, vecs[k].rdy, vecs[k].cause, vecs[k].rn[0], vecs[k].rn[0]});
    end

    // Cycle-exact power-up release: domain i at edge 11+4i, CH=1 instance at edge 11.
    rst = 1'b1; src_ok = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 24; e++) begin
      logic [2:0] exp_rn;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) exp_rn[i] = (e >= 11 + 4 * i);
      check($sformatf("seq_edge%0d", e),
            {exp_rn, (e >= 19), 3'b000, (e >= 11), (e >= 11)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
